uart_tx_packetizer: RTL and testbench

UART_TX_PACKETIZER -- requirements
Module: uart_tx_packetizer

---
 rtl/uart_tx_packetizer_pkg.sv | 25 ++
 rtl/uart_tx_packetizer.sv | 150 +++++++++++++++
 tb/tb_uart_tx_packetizer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_packetizer_pkg.sv
// Shared UART transmit constants and helpers.
//   HEADER_DEFAULT : first byte of every frame unless overridden
//   FRAME_LEN      : bytes per frame (header, four payload bytes, checksum)
//   state_t        : packetizer FSM state encodings
//   payload_chk    : XOR of the four payload bytes
package uart_tx_packetizer_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int         FRAME_LEN      = 6;
  localparam logic [2:0] LAST_IDX       = 3'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_STROBE   = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_WAIT_END = 3'd4
  } state_t;

  // Header is deliberately excluded from the checksum.
  function automatic logic [7:0] payload_chk(input logic [31:0] p);
    return p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_packetizer.sv
// Frames a 32-bit payload into six bytes (HEADER, payload MSB..LSB, XOR
// checksum) and hands them one at a time to a UART writer using a
// start/tx_ready handshake. Pacing comes entirely from tx_ready.
//
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-low
//   send     : one-cycle request to transmit a frame
//   payload  : frame data, captured when send is accepted
//   tx_ready : UART writer idle indication
//   start    : one-cycle strobe to the UART writer
//   TX_data  : byte for the UART writer, valid while start is high
//   busy     : high from accepted send until frame completion
//   done     : one-cycle pulse at frame completion
//   dropped  : one-cycle pulse, one cycle after a send that was refused
module uart_tx_packetizer
  import uart_tx_packetizer_pkg::*;
#(
  parameter logic [7:0] HEADER      = HEADER_DEFAULT,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        send,
  input  logic [31:0] payload,
  input  logic        tx_ready,
  output logic        start,
  output logic [7:0]  TX_data,
  output logic        busy,
  output logic        done,
  output logic        dropped
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  state_t             state;
  logic [2:0]         idx;
  logic [31:0]        payload_q;
  logic [7:0]         chk_q;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [7:0]         cur_byte;
  logic               idx_bad;

  always_comb begin
    cur_byte = 8'h00;
    case (idx)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = payload_q[31:24];
      3'd2:    cur_byte = payload_q[23:16];
      3'd3:    cur_byte = payload_q[15:8];
      3'd4:    cur_byte = payload_q[7:0];
      3'd5:    cur_byte = chk_q;
      default: cur_byte = 8'h00;
    endcase
  end

  // Index values 6 and 7 can only come from an upset; treat as abort.
  assign idx_bad = (idx > LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      idx       <= 3'd0;
      payload_q <= 32'h0;
      chk_q     <= 8'h00;
      tmo_cnt   <= '0;
      start     <= 1'b0;
      TX_data   <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      start   <= 1'b0;
      done    <= 1'b0;
      dropped <= 1'b0;

      if (send && state != ST_IDLE) begin
        dropped <= 1'b1;
      end

      if (state != ST_IDLE && idx_bad) begin
        state <= ST_IDLE;
        idx   <= 3'd0;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            // done is still high in the first IDLE cycle; a send landing
            // there is refused so frames start only from a clean IDLE.
            if (send) begin
              if (done) begin
                dropped <= 1'b1;
              end else begin
                payload_q <= payload;
                chk_q     <= payload_chk(payload);
                idx       <= 3'd0;
                busy      <= 1'b1;
                state     <= ST_WAIT_RDY;
              end
            end
          end

          ST_WAIT_RDY: begin
            if (tx_ready) begin
              start   <= 1'b1;
              TX_data <= cur_byte;
              state   <= ST_STROBE;
            end
          end

          ST_STROBE: begin
            tmo_cnt <= '0;
            state   <= ST_WAIT_ACK;
          end

          ST_WAIT_ACK: begin
            if (!tx_ready) begin
              if (idx == LAST_IDX) begin
                state <= ST_WAIT_END;
              end else begin
                idx   <= idx + 3'd1;
                state <= ST_WAIT_RDY;
              end
            end else if (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1)) begin
              // Writer never took the byte: strobe the same index again.
              state <= ST_WAIT_RDY;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end

          ST_WAIT_END: begin
            if (tx_ready) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end

          default: begin
            state <= ST_IDLE;
            idx   <= 3'd0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_packetizer.sv
module tb_uart_tx_packetizer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        send = 1'b0;
  logic [31:0] payload = 32'h0;
  logic        tx_ready = 1'b1;
  logic        start;
  logic [7:0]  TX_data;
  logic        busy;
  logic        done;
  logic        dropped;

  always #5 clk = ~clk;

  uart_tx_packetizer #(
    .HEADER      (8'hA5),
    .ACK_TIMEOUT (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .send     (send),
    .payload  (payload),
    .tx_ready (tx_ready),
    .start    (start),
    .TX_data  (TX_data),
    .busy     (busy),
    .done     (done),
    .dropped  (dropped)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] cap_q[$];
  int ready_cnt  = 0;
  int ignore_pos = -1;
  int done_count = 0;
  int drop_count = 0;
  int consec_err = 0;
  logic prev_start = 1'b0;

  // UART writer model: tx_ready drops for 10 cycles after each start,
  // except for the capture position named by ignore_pos (left high).
  always @(negedge clk) begin
    if (!reset) begin
      tx_ready   = 1'b1;
      ready_cnt  = 0;
      prev_start = 1'b0;
    end else begin
      if (start && prev_start) consec_err++;
      prev_start = start;
      if (done) done_count++;
      if (dropped) drop_count++;
      if (start) begin
        cap_q.push_back(TX_data);
        if (cap_q.size() - 1 == ignore_pos) begin
          ignore_pos = -1;
        end else begin
          tx_ready  = 1'b0;
          ready_cnt = 10;
        end
      end else if (ready_cnt > 0) begin
        ready_cnt--;
        if (ready_cnt == 0) tx_ready = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_pulse(input logic [31:0] p);
    @(negedge clk);
    payload = p;
    send    = 1'b1;
    @(negedge clk);
    send    = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (cap_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_frame(input string name, input int base,
                             input logic [31:0] p, input logic [7:0] c);
    logic [7:0] e[6];
    logic [7:0] a;
    e[0] = 8'hA5;
    e[1] = p[31:24];
    e[2] = p[23:16];
    e[3] = p[15:8];
    e[4] = p[7:0];
    e[5] = c;
    for (int k = 0; k < 6; k++) begin
      a = (base + k < cap_q.size()) ? cap_q[base + k] : 8'hxx;
      chk($sformatf("%s_b%0d", name, k), {24'h0, a}, {24'h0, e[k]});
    end
  endtask

  typedef struct {
    logic [31:0] p;
    logic [7:0]  c;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit ok;
    int d0;
    int dr0;

    vecs[0] = '{32'h12345678, 8'h08};
    vecs[1] = '{32'hFFFFFFFF, 8'h00};
    vecs[2] = '{32'h000000FF, 8'hFF};
    vecs[3] = '{32'hA5A5A5A5, 8'h00};
    vecs[4] = '{32'h01020408, 8'h0F};
    vecs[5] = '{32'hDEADBEEF, 8'h22};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_start",   start,   0);
    chk("rst_busy",    busy,    0);
    chk("rst_done",    done,    0);
    chk("rst_dropped", dropped, 0);
    chk("rst_txdata",  TX_data, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      cap_q.delete();
      d0 = done_count;
      send_pulse(vecs[v].p);
      chk($sformatf("v%0d_busy_hi", v), busy, 1);
      wait_done(ok);
      chk($sformatf("v%0d_done_seen", v), ok, 1);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_busy_lo", v), busy, 0);
      chk($sformatf("v%0d_done_cnt", v), done_count - d0, 1);
      chk($sformatf("v%0d_nbytes", v), cap_q.size(), 6);
      check_frame($sformatf("v%0d", v), 0, vecs[v].p, vecs[v].c);
    end

    // Writer ignores byte 1 once: timeout then retry of the same byte
    cap_q.delete();
    ignore_pos = 1;
    send_pulse(32'h12345678);
    wait_done(ok);
    chk("tmo_done_seen", ok, 1);
    repeat (3) @(negedge clk);
    chk("tmo_nbytes", cap_q.size(), 7);
    chk("tmo_b0", (cap_q.size() > 0) ? cap_q[0] : 8'hxx, 8'hA5);
    chk("tmo_b1", (cap_q.size() > 1) ? cap_q[1] : 8'hxx, 8'h12);
    chk("tmo_b1_retry", (cap_q.size() > 2) ? cap_q[2] : 8'hxx, 8'h12);
    chk("tmo_b2", (cap_q.size() > 3) ? cap_q[3] : 8'hxx, 8'h34);
    chk("tmo_b5", (cap_q.size() > 6) ? cap_q[6] : 8'hxx, 8'h08);
    chk("tmo_busy_lo", busy, 0);

    // Send while busy (during byte 3) is dropped
    cap_q.delete();
    d0  = done_count;
    dr0 = drop_count;
    send_pulse(32'hCAFEBABE);
    wait_bytes(4, ok);
    chk("drop_reach_b3", ok, 1);
    @(negedge clk);
    payload = 32'h11111111;
    send    = 1'b1;
    @(negedge clk);
    send    = 1'b0;
    chk("drop_pulse", dropped, 1);
    wait_done(ok);
    chk("drop_done_seen", ok, 1);
    repeat (3) @(negedge clk);
    check_frame("drop", 0, 32'hCAFEBABE, 8'h30);
    chk("drop_cnt", drop_count - dr0, 1);
    repeat (100) @(negedge clk);
    chk("drop_no_2nd_frame", cap_q.size(), 6);
    chk("drop_done_cnt", done_count - d0, 1);

    // Reset after byte 2 strobe aborts the frame
    cap_q.delete();
    d0 = done_count;
    send_pulse(32'h12345678);
    wait_bytes(3, ok);
    chk("mrst_reach_b2", ok, 1);
    reset = 1'b0;
    #1;
    chk("mrst_start",   start,   0);
    chk("mrst_busy",    busy,    0);
    chk("mrst_done",    done,    0);
    chk("mrst_dropped", dropped, 0);
    chk("mrst_txdata",  TX_data, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (50) @(negedge clk);
    chk("mrst_no_done", done_count - d0, 0);
    cap_q.delete();
    send_pulse(32'h12345678);
    wait_done(ok);
    chk("mrst_done_seen", ok, 1);
    repeat (3) @(negedge clk);
    check_frame("mrst", 0, 32'h12345678, 8'h08);

    // Send in the done cycle is dropped; send one cycle later is accepted
    cap_q.delete();
    d0  = done_count;
    dr0 = drop_count;
    send_pulse(32'h01020408);
    wait_done(ok);
    chk("b2b_done1_seen", ok, 1);
    payload = 32'hDEADBEEF;
    send    = 1'b1;
    @(negedge clk);
    chk("b2b_drop_in_done", dropped, 1);
    payload = 32'h000000FF;
    send    = 1'b1;
    @(negedge clk);
    send    = 1'b0;
    chk("b2b_busy_hi", busy, 1);
    wait_done(ok);
    chk("b2b_done2_seen", ok, 1);
    repeat (3) @(negedge clk);
    chk("b2b_nbytes", cap_q.size(), 12);
    check_frame("b2b_f1", 0, 32'h01020408, 8'h0F);
    check_frame("b2b_f2", 6, 32'h000000FF, 8'hFF);
    chk("b2b_done_cnt", done_count - d0, 2);
    chk("b2b_drop_cnt", drop_count - dr0, 1);

    chk("start_never_consecutive", consec_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
